// File: rtl/pmem_arbiter_if.sv
// Cache-side and memory-side line-transfer signals around the physical-memory arbiter.
// slave is the arbiter's view; master is the caches plus physical memory.
interface pmem_arbiter_if #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
);
   logic              i_pmem_read;
   logic [ADDR_W-1:0] i_pmem_address;
   logic [LINE_W-1:0] i_pmem_rdata;
   logic              i_pmem_resp;
   logic              d_pmem_read;
   logic              d_pmem_write;
   logic [ADDR_W-1:0] d_pmem_address;
   logic [LINE_W-1:0] d_pmem_wdata;
   logic [LINE_W-1:0] d_pmem_rdata;
   logic              d_pmem_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write, d_pmem_address,
             d_pmem_wdata, pmem_rdata, pmem_resp,
      output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write, d_pmem_address,
             d_pmem_wdata, pmem_rdata, pmem_resp,
      input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter putting I-cache reads and D-cache reads/write-backs onto one memory port.
// Optional performance counters are built only when PMEM_ARB_PERF_EN is defined.
module pmem_arbiter #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   pmem_arbiter_if.slave bus,
   output logic [31:0] perf_i_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_wait_cycles
);
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-5){1'b1}}, 5'b0};

   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;   // 1 when D owned the most recent grant
   logic              rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              i_req, d_req, grant_i, grant_d;

   assign i_req   = bus.i_pmem_read;
   assign d_req   = bus.d_pmem_read | bus.d_pmem_write;
   assign grant_d = (state_q == IDLE) && d_req && (!i_req || !last_d_q);
   assign grant_i = (state_q == IDLE) && i_req && !grant_d;

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d = SERVE_D;
               // An illegal read+write request is treated as a write-back
               wr_d    = bus.d_pmem_write;
               rd_d    = !bus.d_pmem_write;
               addr_d  = bus.d_pmem_address & LINE_MASK;
               wdata_d = bus.d_pmem_wdata;
            end else if (grant_i) begin
               state_d = SERVE_I;
               rd_d    = 1'b1;
               wr_d    = 1'b0;
               addr_d  = bus.i_pmem_address & LINE_MASK;
            end
         end
         SERVE_I, SERVE_D: begin
            if (bus.pmem_resp) begin
               state_d  = IDLE;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
               last_d_d = (state_q == SERVE_D);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign bus.pmem_read    = rd_q;
   assign bus.pmem_write   = wr_q;
   assign bus.pmem_address = addr_q;
   assign bus.pmem_wdata   = wdata_q;
   assign bus.i_pmem_rdata = bus.pmem_rdata;
   assign bus.d_pmem_rdata = bus.pmem_rdata;
   assign bus.i_pmem_resp  = bus.pmem_resp && (state_q == SERVE_I);
   assign bus.d_pmem_resp  = bus.pmem_resp && (state_q == SERVE_D);

   a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.d_pmem_read && bus.d_pmem_write))
      else $error("pmem_arbiter: d_pmem_read and d_pmem_write asserted together");

`ifdef PMEM_ARB_PERF_EN
   logic [31:0] pi_q, pi_d, pd_q, pd_d, pw_q, pw_d;
   logic        waiting;

   assign waiting = (i_req && state_q != SERVE_I) || (d_req && state_q != SERVE_D);

   always_comb begin
      pi_d = pi_q;
      pd_d = pd_q;
      pw_d = pw_q;
      if (grant_i && pi_q != '1) pi_d = pi_q + 32'd1;
      if (grant_d && pd_q != '1) pd_d = pd_q + 32'd1;
      if (waiting && pw_q != '1) pw_d = pw_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pi_q <= '0;
         pd_q <= '0;
         pw_q <= '0;
      end else begin
         pi_q <= pi_d;
         pd_q <= pd_d;
         pw_q <= pw_d;
      end
   end

   assign perf_i_grants    = pi_q;
   assign perf_d_grants    = pd_q;
   assign perf_wait_cycles = pw_q;
`else
   assign perf_i_grants    = '0;
   assign perf_d_grants    = '0;
   assign perf_wait_cycles = '0;
`endif
endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed checks of pmem_arbiter: grant timing, round-robin, alignment, resets and counters.
module tb_pmem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] perf_i_grants, perf_d_grants, perf_wait_cycles;
   int n_cmp = 0;
   int n_bad = 0;

   pmem_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();

   pmem_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_wait_cycles(perf_wait_cycles)
   );

   always #5 clk = ~clk;

`ifdef PMEM_ARB_PERF_EN
   localparam logic [31:0] EXP_I_GR = 32'd1, EXP_D_GR = 32'd1, EXP_WAIT = 32'd5;
`else
   localparam logic [31:0] EXP_I_GR = 32'd0, EXP_D_GR = 32'd0, EXP_WAIT = 32'd0;
`endif

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      bus.i_pmem_read = 0; bus.i_pmem_address = '0;
      bus.d_pmem_read = 0; bus.d_pmem_write = 0; bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
      bus.pmem_rdata = '0; bus.pmem_resp = 0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      n_cmp++; if (bus.pmem_read !== 1'b0) begin n_bad++; $display("FAIL reset_read got=%b exp=0", bus.pmem_read); end
      n_cmp++; if (bus.pmem_write !== 1'b0) begin n_bad++; $display("FAIL reset_write got=%b exp=0", bus.pmem_write); end
      n_cmp++; if (bus.pmem_address !== 32'h0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", bus.pmem_address); end
      n_cmp++; if (bus.pmem_wdata !== 256'h0) begin n_bad++; $display("FAIL reset_wdata got=%h exp=0", bus.pmem_wdata); end
      n_cmp++; if ({perf_i_grants, perf_d_grants, perf_wait_cycles} !== 96'h0) begin n_bad++;
         $display("FAIL reset_perf got=%h/%h/%h exp=0", perf_i_grants, perf_d_grants, perf_wait_cycles); end
      // stray memory response while idle must not reach either cache
      bus.pmem_resp = 1'b1;
      #1;
      n_cmp++; if ({bus.i_pmem_resp, bus.d_pmem_resp} !== 2'b00) begin n_bad++;
         $display("FAIL idle_resp got=%b%b exp=00", bus.i_pmem_resp, bus.d_pmem_resp); end
      tick();
      bus.pmem_resp = 1'b0;
      n_cmp++; if (bus.pmem_read !== 1'b0) begin n_bad++; $display("FAIL idle_resp_read got=%b exp=0", bus.pmem_read); end
   endtask

   task automatic test_i_read;
      logic [255:0] line;
      line = {8{32'hC0DE_0060}};
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0060;
      #1;
      n_cmp++; if (bus.pmem_read !== 1'b0) begin n_bad++; $display("FAIL i_not_comb got=%b exp=0", bus.pmem_read); end
      tick();
      n_cmp++; if (bus.pmem_read !== 1'b1) begin n_bad++; $display("FAIL i_strobe got=%b exp=1", bus.pmem_read); end
      n_cmp++; if (bus.pmem_address !== 32'h0000_0060) begin n_bad++; $display("FAIL i_addr got=%h exp=00000060", bus.pmem_address); end
      tick(); tick(); tick();
      bus.pmem_resp = 1'b1; bus.pmem_rdata = line;
      #1;
      n_cmp++; if (bus.i_pmem_resp !== 1'b1) begin n_bad++; $display("FAIL i_resp got=%b exp=1", bus.i_pmem_resp); end
      n_cmp++; if (bus.i_pmem_rdata !== line) begin n_bad++; $display("FAIL i_rdata got=%h exp=%h", bus.i_pmem_rdata, line); end
      n_cmp++; if (bus.d_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL i_dresp got=%b exp=0", bus.d_pmem_resp); end
      tick();
      bus.i_pmem_read = 1'b0; bus.pmem_resp = 1'b0;
      n_cmp++; if (bus.pmem_read !== 1'b0) begin n_bad++; $display("FAIL i_strobe_drop got=%b exp=0", bus.pmem_read); end
      tick();
      n_cmp++; if (bus.pmem_read !== 1'b0) begin n_bad++; $display("FAIL i_no_regrant got=%b exp=0", bus.pmem_read); end
   endtask

   task automatic test_conflict;
      logic [255:0] wd;
      wd = {32{8'hA5}};
      do_reset();
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h100;
      bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h200; bus.d_pmem_wdata = wd;
      tick();
      n_cmp++; if ({bus.pmem_write, bus.pmem_read} !== 2'b10) begin n_bad++;
         $display("FAIL cf_d_strobe got=%b%b exp=10", bus.pmem_write, bus.pmem_read); end
      n_cmp++; if (bus.pmem_address !== 32'h200) begin n_bad++; $display("FAIL cf_d_addr got=%h exp=00000200", bus.pmem_address); end
      n_cmp++; if (bus.pmem_wdata !== wd) begin n_bad++; $display("FAIL cf_wdata got=%h exp=%h", bus.pmem_wdata, wd); end
      tick(); tick();
      n_cmp++; if ({bus.pmem_write, bus.pmem_address, bus.pmem_wdata} !== {1'b1, 32'h200, wd}) begin n_bad++;
         $display("FAIL cf_stable got=%b %h exp=1 00000200", bus.pmem_write, bus.pmem_address); end
      bus.pmem_resp = 1'b1;
      #1;
      n_cmp++; if ({bus.d_pmem_resp, bus.i_pmem_resp} !== 2'b10) begin n_bad++;
         $display("FAIL cf_d_resp got=%b%b exp=10", bus.d_pmem_resp, bus.i_pmem_resp); end
      tick();
      bus.d_pmem_write = 1'b0; bus.pmem_resp = 1'b0;
      n_cmp++; if ({bus.pmem_write, bus.pmem_read} !== 2'b00) begin n_bad++;
         $display("FAIL cf_idle got=%b%b exp=00", bus.pmem_write, bus.pmem_read); end
      tick();
      n_cmp++; if ({bus.pmem_write, bus.pmem_read} !== 2'b01) begin n_bad++;
         $display("FAIL cf_i_strobe got=%b%b exp=01", bus.pmem_write, bus.pmem_read); end
      n_cmp++; if (bus.pmem_address !== 32'h100) begin n_bad++; $display("FAIL cf_i_addr got=%h exp=00000100", bus.pmem_address); end
      bus.pmem_resp = 1'b1;
      #1;
      n_cmp++; if ({bus.d_pmem_resp, bus.i_pmem_resp} !== 2'b01) begin n_bad++;
         $display("FAIL cf_i_resp got=%b%b exp=01", bus.d_pmem_resp, bus.i_pmem_resp); end
      tick();
      bus.i_pmem_read = 1'b0; bus.pmem_resp = 1'b0;
      n_cmp++; if (perf_i_grants !== EXP_I_GR) begin n_bad++; $display("FAIL perf_i got=%0d exp=%0d", perf_i_grants, EXP_I_GR); end
      n_cmp++; if (perf_d_grants !== EXP_D_GR) begin n_bad++; $display("FAIL perf_d got=%0d exp=%0d", perf_d_grants, EXP_D_GR); end
      n_cmp++; if (perf_wait_cycles !== EXP_WAIT) begin n_bad++; $display("FAIL perf_wait got=%0d exp=%0d", perf_wait_cycles, EXP_WAIT); end
   endtask

   task automatic test_alternate;
      logic [31:0] ia, da;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         ia = 32'h1000 + 32'(k) * 32'h40;
         da = 32'h2000 + 32'(k) * 32'h40;
         bus.i_pmem_read = 1'b1; bus.i_pmem_address = ia;
         bus.d_pmem_read = 1'b1; bus.d_pmem_address = da;
         tick();
         n_cmp++; if ({bus.pmem_read, bus.pmem_address} !== {1'b1, da}) begin n_bad++;
            $display("FAIL alt_d[%0d] got=%b %h exp=1 %h", k, bus.pmem_read, bus.pmem_address, da); end
         bus.pmem_resp = 1'b1;
         tick();
         bus.d_pmem_read = 1'b0; bus.pmem_resp = 1'b0;
         tick();
         n_cmp++; if ({bus.pmem_read, bus.pmem_address} !== {1'b1, ia}) begin n_bad++;
            $display("FAIL alt_i[%0d] got=%b %h exp=1 %h", k, bus.pmem_read, bus.pmem_address, ia); end
         bus.pmem_resp = 1'b1;
         tick();
         bus.i_pmem_read = 1'b0; bus.pmem_resp = 1'b0;
      end
   endtask

   task automatic test_addr_align;
      logic [255:0] line;
      line = {4{64'hDEAD_BEEF_0123_4567}};
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_123F;
      tick();
      n_cmp++; if (bus.pmem_address !== 32'h0000_1220) begin n_bad++; $display("FAIL align got=%h exp=00001220", bus.pmem_address); end
      bus.pmem_resp = 1'b1; bus.pmem_rdata = line;
      #1;
      n_cmp++; if ({bus.d_pmem_resp, bus.d_pmem_rdata} !== {1'b1, line}) begin n_bad++;
         $display("FAIL align_resp got=%b %h exp=1 %h", bus.d_pmem_resp, bus.d_pmem_rdata, line); end
      tick();
      bus.d_pmem_read = 1'b0; bus.pmem_resp = 1'b0;
   endtask

   task automatic test_drop;
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h400;
      tick();
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h500;
      tick();
      bus.i_pmem_read = 1'b0;
      bus.pmem_resp = 1'b1;
      tick();
      bus.d_pmem_read = 1'b0; bus.pmem_resp = 1'b0;
      tick();
      n_cmp++; if (bus.pmem_read !== 1'b0) begin n_bad++; $display("FAIL drop_forgotten got=%b exp=0", bus.pmem_read); end
   endtask

   task automatic test_reset_mid;
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h300;
      tick();
      n_cmp++; if (bus.pmem_read !== 1'b1) begin n_bad++; $display("FAIL rm_strobe got=%b exp=1", bus.pmem_read); end
      rst_n = 1'b0; bus.d_pmem_read = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin n_bad++;
         $display("FAIL rm_strobes got=%b%b exp=00", bus.pmem_read, bus.pmem_write); end
      bus.pmem_resp = 1'b1;
      #1;
      n_cmp++; if ({bus.i_pmem_resp, bus.d_pmem_resp} !== 2'b00) begin n_bad++;
         $display("FAIL rm_late_resp got=%b%b exp=00", bus.i_pmem_resp, bus.d_pmem_resp); end
      tick();
      bus.pmem_resp = 1'b0;
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h80;
      tick();
      n_cmp++; if ({bus.pmem_read, bus.pmem_address} !== {1'b1, 32'h80}) begin n_bad++;
         $display("FAIL rm_idle_grant got=%b %h exp=1 00000080", bus.pmem_read, bus.pmem_address); end
      bus.pmem_resp = 1'b1;
      tick();
      bus.i_pmem_read = 1'b0; bus.pmem_resp = 1'b0;
   endtask

   initial begin
      test_reset();
      test_i_read();
      test_conflict();
      test_alternate();
      test_addr_align();
      test_drop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
